// File: rtl/byte_lane_dly_loader_pkg.sv
// rtl/byte_lane_dly_loader_pkg.sv - byte-lane delay address map, FSM states and mapping helpers
package byte_lane_dly_loader_pkg;

    localparam int NUM_DLY = 19;

    localparam logic [4:0] DQ_ODLY_BASE = 5'd0;
    localparam logic [4:0] DQS_ODLY     = 5'd8;
    localparam logic [4:0] DM_ODLY      = 5'd9;
    localparam logic [4:0] DQ_IDLY_BASE = 5'd16;
    localparam logic [4:0] DQS_IDLY     = 5'd24;

    localparam logic [4:0] LAST_IDX     = 5'(NUM_DLY - 1);
    // Table indices 10..18 hold the input-delay addresses 16..24.
    localparam logic [4:0] IDLY_IDX     = DM_ODLY + 5'd1;
    localparam logic [4:0] IDLY_OFFSET  = DQ_IDLY_BASE - IDLY_IDX;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        SET,
        DONE
    } state_e;

    function automatic logic addr_valid(input logic [4:0] addr);
        return (addr >= DQ_ODLY_BASE && addr <= DM_ODLY) ||
               (addr >= DQ_IDLY_BASE && addr <= DQS_IDLY);
    endfunction

    function automatic logic [4:0] addr2idx(input logic [4:0] addr);
        return (addr >= DQ_IDLY_BASE) ? addr - IDLY_OFFSET : addr;
    endfunction

    function automatic logic [4:0] idx2addr(input logic [4:0] idx);
        return (idx >= IDLY_IDX) ? idx + IDLY_OFFSET : idx;
    endfunction

endpackage

// File: rtl/dly_shadow_table.sv
// rtl/dly_shadow_table.sv - 19x8 delay shadow table, one sync write port, one comb read port
module dly_shadow_table
    import byte_lane_dly_loader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we_i,
    input  logic [4:0] widx_i,
    input  logic [7:0] wdata_i,
    input  logic [4:0] ridx_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [NUM_DLY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_DLY; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && widx_i <= LAST_IDX) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (ridx_i <= LAST_IDX) begin
            rdata_o = mem_q[ridx_i];
        end
    end

endmodule

// File: rtl/byte_lane_dly_loader.sv
// rtl/byte_lane_dly_loader.sv - sequences shadow-table delays into a byte lane via ld_delay/set strobes
module byte_lane_dly_loader
    import byte_lane_dly_loader_pkg::*;
#(
    parameter int unsigned SET_GAP       = 1,
    parameter bit          SET_AFTER_ONE = 1'b1
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start_all,
    input  logic       start_one,
    input  logic [4:0] one_addr,
    output logic [7:0] dly_data,
    output logic [4:0] dly_addr,
    output logic       ld_delay,
    output logic       set,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] GAP_INIT = 4'(SET_GAP - 1);

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       one_q, one_d;
    logic [3:0] gap_q, gap_d;
    logic       err_d;

    logic       rst_sync_q;
    logic [7:0] dly_data_q;
    logic [4:0] dly_addr_q;
    logic       ld_q, set_q, busy_q, done_q, err_q;

    logic       tbl_we;
    logic [7:0] tbl_rdata;

    assign tbl_we = wr_en && addr_valid(wr_addr) && !busy_q;

    dly_shadow_table u_table (
        .clk_i   (clk_div),
        .rst_ni  (rst_n),
        .we_i    (tbl_we),
        .widx_i  (addr2idx(wr_addr)),
        .wdata_i (wr_data),
        .ridx_i  (idx_d),
        .rdata_o (tbl_rdata)
    );

    // Reset release is retimed to clk_div; starts are only honoured once this flop is set.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        one_d   = one_q;
        gap_d   = gap_q;
        err_d   = 1'b0;

        if (wr_en && (!addr_valid(wr_addr) || busy_q)) begin
            err_d = 1'b1;
        end
        if ((start_all || start_one) && busy_q) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (rst_sync_q) begin
                    if (start_all) begin
                        state_d = LOAD;
                        idx_d   = '0;
                        one_d   = 1'b0;
                    end else if (start_one) begin
                        if (addr_valid(one_addr)) begin
                            state_d = LOAD;
                            idx_d   = addr2idx(one_addr);
                            one_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            LOAD: begin
                if (one_q || idx_q == LAST_IDX) begin
                    if (!one_q || SET_AFTER_ONE) begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SET;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            SET:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            one_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            one_q   <= one_d;
            gap_q   <= gap_d;
        end
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            dly_data_q <= '0;
            dly_addr_q <= '0;
            ld_q       <= 1'b0;
            set_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_q   <= (state_d == LOAD);
            set_q  <= (state_d == SET);
            done_q <= (state_d == DONE);
            busy_q <= (state_d != IDLE);
            err_q  <= err_d;
            if (state_d == LOAD) begin
                dly_addr_q <= idx2addr(idx_d);
                dly_data_q <= tbl_rdata;
            end
        end
    end

    assign dly_data = dly_data_q;
    assign dly_addr = dly_addr_q;
    assign ld_delay = ld_q;
    assign set      = set_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
